tsf_timer_multi: RTL
====================

Name: tsf_timer_multi

Overview:
- Parametrised successor to the single-channel TSF timer.
- Programmable microsecond prescaler, so one RTL build serves any clock frequency.
- Atomic absolute-load and signed-adjust of the TSF.
- NUM_CMP independent compare channels, each one-shot or periodic, for beacon/TBTT, NAV end and slot timers.
- Sits in xpu. Feeds TSF to tx_control and csma; drives beacon/interrupt logic from cmp_hit.

Parameters:
- TIMER_WIDTH, 64, TSF width in bits.
- DIV_WIDTH, 8, prescaler width.
- NUM_CMP, 4, number of compare channels.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- tick_div  in  DIV_WIDTH  clk cycles per microsecond minus 1 (static or quasi-static).
- load_en  in  1  single-cycle load strobe.
- load_mode  in  1  0 = absolute load, 1 = add signed offset.
- load_val  in  TIMER_WIDTH  load value or two's-complement offset.
- reset_tsf  in  1  level; zeroes the TSF at the next tick.
- cmp_target  in  NUM_CMP*TIMER_WIDTH  per-channel first target; channel i at bits [i*W +: W].
- cmp_period  in  NUM_CMP*TIMER_WIDTH  per-channel period; 0 = one-shot.
- cmp_arm  in  NUM_CMP  per-channel arm strobe.
- cmp_disarm  in  NUM_CMP  per-channel disarm strobe.
- tsf_val  out  TIMER_WIDTH  running TSF in microseconds.
- tsf_log_val  out  TIMER_WIDTH  TSF value captured at the last reset_tsf.
- tsf_pulse_1M  out  1  one-cycle pulse per TSF increment.
- cmp_hit  out  NUM_CMP  one-cycle hit pulse per channel.
- cmp_armed  out  NUM_CMP  channel armed status.
- cmp_late  out  NUM_CMP  sticky: periodic re-target already in the past.

Behaviour:
- Reset: all outputs, the prescaler and internal targets = 0; all channels disarmed.
- Prescaler: presc counts 0..tick_div.
  - At presc >= tick_div (a "tick"): presc <= 0, and tsf_val <= tsf_val + 1.
  - Using >= means a reduction of tick_div mid-count wraps at the next cycle.
  - tick_div = 0 gives a tick every cycle.
- tsf_pulse_1M = registered tick; it is high the same cycle tsf_val shows the incremented value.
- TSF priority (highest first): load_en > reset_tsf-on-tick > tick increment.
  - Absolute load: tsf_val <= load_val, presc <= 0, tsf_pulse_1M <= 0 that cycle.
  - Add load: tsf_val <= tsf_val + load_val, modulo 2^TIMER_WIDTH; presc is unchanged and the pending tick increment is dropped that cycle.
  - reset_tsf on tick: tsf_log_val <= tsf_val, tsf_val <= 0.
  - All arithmetic wraps silently at 2^TIMER_WIDTH.
- Compare channel i, with internal registers tgt[i] and per[i]:
  - cmp_arm[i]: tgt <= cmp_target slice, per <= cmp_period slice, armed <= 1, late <= 0.
  - Arming an already-armed channel reloads it.
  - cmp_disarm[i]: armed <= 0. If arm and disarm occur in the same cycle, disarm wins.
  - Hit condition: armed && tsf_val >= tgt (unsigned), evaluated on the registered tsf_val. cmp_hit[i] is high the next cycle and lasts one cycle.
  - On hit with per == 0: armed <= 0.
  - On hit with per != 0: tgt <= tgt + per and the channel stays armed. If (tgt + per) <= tsf_val, late <= 1 and the channel hits again on consecutive cycles until it catches up.
  - An arm in the same cycle as a hit condition suppresses that hit and reloads the channel.
- A forward TSF load past armed targets causes immediate hits (catch-up). A backward load delays them. No target is adjusted by a load.
- Channels are fully independent; simultaneous hits on several channels are allowed.
- Latency: tsf_val changes 1 cycle after a tick or load; cmp_hit follows 1 cycle after the tsf_val match.
- Asserting rstn low mid-operation clears everything immediately (asynchronous).

Optional Feature:
- Macro TSF_SNAPSHOT_EN.
- When defined, the block adds:
  - input snap_req [NUM_CMP-1:0];
  - output snap_val [NUM_CMP*TIMER_WIDTH-1:0], each slice reset 0.
- Behaviour with the macro: on snap_req[i], slice i <= tsf_val (the pre-update value that cycle). This gives per-source RX/TX timestamps.
- Without the macro: the ports do not exist and no snapshot registers are generated.

Test Plan:
- Prescaler: tick_div=19, run 200 cycles after reset -> tsf_val=10; tsf_pulse_1M every 20 cycles; change tick_div to 39 -> period becomes 40.
- Absolute load: tsf_val=100, load_mode=0, load_val=0x1000 -> tsf_val=0x1000 next cycle; the next pulse arrives tick_div+1 cycles later.
- Add load: tsf_val=0x1000, load_val=-16 -> 0xFF0. Then tsf_val=2^64-1 with a tick -> wraps to 0.
- One-shot: arm ch0 with target 50, period 0 at tsf 10 -> single cmp_hit[0] one cycle after tsf_val=50; cmp_armed[0]=0 afterwards.
- Periodic and late: ch1 with target 100, period 100 -> hits at 100/200/300. Then load tsf 550 -> hits on consecutive cycles at targets 400, 500 with cmp_late[1]=1; next hit at 600.
- Conflicts: arm+disarm together -> not armed. reset_tsf and load_en on the same tick cycle -> load_val wins and tsf_log_val is unchanged.

Source files
------------

// File: rtl/tsf_timer_multi_if.sv
// Host-side bundle for tsf_timer_multi: timebase control, compare programming and status.
// The snapshot signals exist only when TSF_SNAPSHOT_EN is defined.
interface tsf_timer_multi_if #(
  parameter int TIMER_WIDTH = 64,
  parameter int DIV_WIDTH   = 8,
  parameter int NUM_CMP     = 4
);
  logic [DIV_WIDTH-1:0]           tick_div;
  logic                           load_en;
  logic                           load_mode;
  logic [TIMER_WIDTH-1:0]         load_val;
  logic                           reset_tsf;
  logic [NUM_CMP*TIMER_WIDTH-1:0] cmp_target;
  logic [NUM_CMP*TIMER_WIDTH-1:0] cmp_period;
  logic [NUM_CMP-1:0]             cmp_arm;
  logic [NUM_CMP-1:0]             cmp_disarm;
  logic [TIMER_WIDTH-1:0]         tsf_val;
  logic [TIMER_WIDTH-1:0]         tsf_log_val;
  logic                           tsf_pulse_1M;
  logic [NUM_CMP-1:0]             cmp_hit;
  logic [NUM_CMP-1:0]             cmp_armed;
  logic [NUM_CMP-1:0]             cmp_late;
`ifdef TSF_SNAPSHOT_EN
  logic [NUM_CMP-1:0]             snap_req;
  logic [NUM_CMP*TIMER_WIDTH-1:0] snap_val;
`endif

  modport master (
    output tick_div, load_en, load_mode, load_val, reset_tsf,
    output cmp_target, cmp_period, cmp_arm, cmp_disarm,
`ifdef TSF_SNAPSHOT_EN
    output snap_req,
    input  snap_val,
`endif
    input  tsf_val, tsf_log_val, tsf_pulse_1M, cmp_hit, cmp_armed, cmp_late
  );

  modport slave (
    input  tick_div, load_en, load_mode, load_val, reset_tsf,
    input  cmp_target, cmp_period, cmp_arm, cmp_disarm,
`ifdef TSF_SNAPSHOT_EN
    input  snap_req,
    output snap_val,
`endif
    output tsf_val, tsf_log_val, tsf_pulse_1M, cmp_hit, cmp_armed, cmp_late
  );
endinterface

// File: rtl/tsf_timer_multi.sv
// Microsecond TSF timer with programmable prescaler, atomic load/adjust and NUM_CMP compare channels.
// Optional per-source timestamp capture is built when TSF_SNAPSHOT_EN is defined.
module tsf_timer_multi #(
  parameter int TIMER_WIDTH = 64,
  parameter int DIV_WIDTH   = 8,
  parameter int NUM_CMP     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  tsf_timer_multi_if.slave bus
);
  localparam int W = TIMER_WIDTH;

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base,
                                            input logic signed [W-1:0] offset);
    logic [W-1:0] sum;
    sum = base + $unsigned(offset);
    return sum;
  endfunction

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [W-1:0]         tsf_q, tsf_d;
  logic [W-1:0]         log_q, log_d;
  logic                 pulse_q, pulse_d;
  logic                 tick;
  logic signed [W-1:0]  load_off;

  logic [W-1:0]         tgt_q [NUM_CMP];
  logic [W-1:0]         tgt_d [NUM_CMP];
  logic [W-1:0]         per_q [NUM_CMP];
  logic [W-1:0]         per_d [NUM_CMP];
  logic [W-1:0]         nxt_tgt [NUM_CMP];
  logic [NUM_CMP-1:0]   armed_q, armed_d;
  logic [NUM_CMP-1:0]   late_q, late_d;
  logic [NUM_CMP-1:0]   hit_q, hit_d;

  // >= rather than == so that shrinking tick_div mid-count wraps on the next cycle.
  assign tick     = (presc_q >= bus.tick_div);
  assign load_off = $signed(bus.load_val);

  always_comb begin
    presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
    tsf_d   = tsf_q;
    log_d   = log_q;
    pulse_d = 1'b0;
    if (bus.load_en) begin
      if (!bus.load_mode) begin
        tsf_d   = bus.load_val;
        presc_d = '0;
      end else begin
        tsf_d = wrap_add(tsf_q, load_off);
      end
    end else if (tick) begin
      pulse_d = 1'b1;
      if (bus.reset_tsf) begin
        log_d = tsf_q;
        tsf_d = '0;
      end else begin
        tsf_d = tsf_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
      tsf_q   <= '0;
      log_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tsf_q   <= tsf_d;
      log_q   <= log_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CMP; i++) begin
      nxt_tgt[i] = tgt_q[i] + per_q[i];
    end
  end

  // Per-channel priority: disarm, then arm (which also swallows a coincident hit), then hit.
  always_comb begin
    armed_d = armed_q;
    late_d  = late_q;
    hit_d   = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      tgt_d[i] = tgt_q[i];
      per_d[i] = per_q[i];
      if (bus.cmp_disarm[i]) begin
        armed_d[i] = 1'b0;
      end else if (bus.cmp_arm[i]) begin
        tgt_d[i]   = bus.cmp_target[i*W +: W];
        per_d[i]   = bus.cmp_period[i*W +: W];
        armed_d[i] = 1'b1;
        late_d[i]  = 1'b0;
      end else if (armed_q[i] && (tsf_q >= tgt_q[i])) begin
        hit_d[i] = 1'b1;
        if (per_q[i] == '0) begin
          armed_d[i] = 1'b0;
        end else begin
          tgt_d[i] = nxt_tgt[i];
          if (nxt_tgt[i] <= tsf_q) begin
            late_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CMP; i++) begin
        tgt_q[i] <= '0;
        per_q[i] <= '0;
      end
      armed_q <= '0;
      late_q  <= '0;
      hit_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        tgt_q[i] <= tgt_d[i];
        per_q[i] <= per_d[i];
      end
      armed_q <= armed_d;
      late_q  <= late_d;
      hit_q   <= hit_d;
    end
  end

`ifdef TSF_SNAPSHOT_EN
  logic [NUM_CMP*W-1:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (bus.snap_req[i]) begin
        snap_d[i*W +: W] = tsf_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign bus.snap_val = snap_q;
`endif

  assign bus.tsf_val      = tsf_q;
  assign bus.tsf_log_val  = log_q;
  assign bus.tsf_pulse_1M = pulse_q;
  assign bus.cmp_hit      = hit_q;
  assign bus.cmp_armed    = armed_q;
  assign bus.cmp_late     = late_q;
endmodule
